// File: rtl/simple_instr_fetch.sv
// Single-issue instruction fetch: issues word-sized imem requests, buffers in-order
// responses in a small queue, and presents them to decode with static not-taken prediction.
module simple_instr_fetch #(
    parameter int                     VADDR_WIDTH      = 32,
    parameter int                     MAX_ILEN         = 32,
    parameter int                     XCPT_CAUSE_WIDTH = 32,
    parameter int                     FQ_DEPTH         = 4,
    parameter logic [VADDR_WIDTH-1:0] BOOT_ADDR        = 32'h0000_1000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    output logic                        imem_req_valid_o,
    input  logic                        imem_req_ready_i,
    output logic [VADDR_WIDTH-1:0]      imem_req_addr_o,
    input  logic                        imem_rsp_valid_i,
    input  logic [MAX_ILEN-1:0]         imem_rsp_data_i,
    input  logic                        imem_rsp_error_i,
    input  logic                        redirect_valid_i,
    input  logic [VADDR_WIDTH-1:0]      redirect_pc_i,
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [VADDR_WIDTH-1:0]      instr_pc_o,
    output logic [MAX_ILEN-1:0]         instr_content_o,
    output logic                        bp_is_branch_o,
    output logic                        bp_decision_o,
    output logic [VADDR_WIDTH-1:0]      bp_pred_addr_o,
    output logic                        xcpt_valid_o,
    output logic [VADDR_WIDTH-1:0]      xcpt_origin_o,
    output logic [XCPT_CAUSE_WIDTH-1:0] xcpt_cause_o
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FQ_DEPTH);

    typedef enum logic {RUN, HALT} state_e;

    // cause: 1 = access fault, 0 = misaligned redirect (only meaningful with error set)
    typedef struct packed {
        logic [VADDR_WIDTH-1:0] pc;
        logic [MAX_ILEN-1:0]    data;
        logic                   error;
        logic                   cause;
    } entry_t;

    state_e                 state_q, state_d;
    logic [VADDR_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       discard;
    logic [CNT_W-1:0]       fq_count;
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    entry_t                 fq_mem [FQ_DEPTH];

    logic                   redirect_aligned;
    logic                   req_fire;
    logic                   rsp_push;
    logic                   pop;
    logic [CNT_W:0]         in_flight;
    logic [VADDR_WIDTH-1:0] rsp_pc;
    entry_t                 head;
    logic                   head_present;
    logic                   wr_en;
    logic [PTR_W-1:0]       wr_idx;
    entry_t                 wr_entry;

    assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);
    assign in_flight        = {1'b0, fq_count} + {1'b0, outstanding};
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;
    assign rsp_push         = imem_rsp_valid_i & ~redirect_valid_i & (discard == '0);
    assign pop              = instr_valid_o & instr_ready_i;

    // Requests are consecutive words, so the oldest live one sits this far behind fetch_pc.
    assign rsp_pc = fetch_pc - VADDR_WIDTH'({outstanding, 2'b00});

    assign imem_req_valid_o = ~rst_i & (state_q == RUN) & ~redirect_valid_i
                              & (in_flight < {1'b0, DEPTH});
    assign imem_req_addr_o  = fetch_pc;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can form.
    always_comb begin
        state_d = state_q;
        if (redirect_valid_i) begin
            state_d = redirect_aligned ? RUN : HALT;
        end else if (rsp_push && imem_rsp_error_i) begin
            state_d = HALT;
        end
    end

    always_comb begin
        wr_en    = rsp_push;
        wr_idx   = wr_ptr;
        wr_entry = '{pc: rsp_pc, data: imem_rsp_data_i,
                     error: imem_rsp_error_i, cause: imem_rsp_error_i};
        if (redirect_valid_i) begin
            wr_en    = ~redirect_aligned;
            wr_idx   = '0;
            wr_entry = '{pc: redirect_pc_i, data: '0, error: 1'b1, cause: 1'b0};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            fetch_pc    <= BOOT_ADDR;
            outstanding <= '0;
            discard     <= '0;
            fq_count    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state_q     <= state_d;
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_i);
            if (redirect_valid_i) begin
                if (redirect_aligned) begin
                    fetch_pc <= redirect_pc_i;
                end
                discard  <= outstanding - CNT_W'(imem_rsp_valid_i);
                fq_count <= redirect_aligned ? '0 : CNT_W'(1);
                rd_ptr   <= '0;
                wr_ptr   <= redirect_aligned ? '0 : PTR_W'(1);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + VADDR_WIDTH'(4);
                end
                if (imem_rsp_valid_i && discard != '0) begin
                    discard <= discard - CNT_W'(1);
                end
                fq_count <= fq_count + CNT_W'(rsp_push) - CNT_W'(pop);
                if (rsp_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // NOTE: queue storage has no reset; fq_count qualifies every read, so stale entries are never seen.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            fq_mem[wr_idx] <= wr_entry;
        end
    end

    assign head         = fq_mem[rd_ptr];
    assign head_present = (fq_count != '0);

    assign instr_valid_o   = head_present & ~redirect_valid_i;
    assign instr_pc_o      = head_present ? head.pc : '0;
    assign instr_content_o = (head_present && !head.error) ? head.data : '0;

    assign bp_is_branch_o = (instr_content_o[6:0] == 7'b1100011) ||
                            (instr_content_o[6:0] == 7'b1101111) ||
                            (instr_content_o[6:0] == 7'b1100111);
    assign bp_decision_o  = 1'b0;
    assign bp_pred_addr_o = instr_pc_o + VADDR_WIDTH'(4);

    assign xcpt_valid_o  = instr_valid_o & head.error;
    assign xcpt_origin_o = instr_pc_o;
    assign xcpt_cause_o  = head_present ? XCPT_CAUSE_WIDTH'(head.cause) : '0;

endmodule

// File: tb/tb_simple_instr_fetch.sv
// Cycle-by-cycle directed bench for simple_instr_fetch: a table of input/expected-output
// rows followed by a streaming sequence with a one-cycle-latency memory.
module tb_simple_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_pc, instr_content;
    logic        bp_is_branch, bp_decision;
    logic [31:0] bp_pred_addr;
    logic        xcpt_valid;
    logic [31:0] xcpt_origin, xcpt_cause;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simple_instr_fetch dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .imem_rsp_error_i (rsp_error),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_pc_o       (instr_pc),
        .instr_content_o  (instr_content),
        .bp_is_branch_o   (bp_is_branch),
        .bp_decision_o    (bp_decision),
        .bp_pred_addr_o   (bp_pred_addr),
        .xcpt_valid_o     (xcpt_valid),
        .xcpt_origin_o    (xcpt_origin),
        .xcpt_cause_o     (xcpt_cause)
    );

    typedef struct {
        bit          rst, rdy, rv;
        logic [31:0] rd;
        bit          re, rdr;
        logic [31:0] rpc;
        bit          ird;
        bit          rqv;
        logic [31:0] rqa;
        bit          iv;
        logic [31:0] ipc, ic;
        bit          br, xv;
        logic [31:0] xc;
    } vec_t;

    typedef struct packed {
        logic        rqv;
        logic [31:0] rqa;
        logic        iv;
        logic [31:0] ipc, ic;
        logic        br, bd;
        logic [31:0] pred;
        logic        xv;
        logic [31:0] xo, xc;
    } obs_t;

    vec_t vecs[$];

    task automatic row(input bit rst_v, rdy, rv, input logic [31:0] rd, input bit re, rdr,
                       input logic [31:0] rpc, input bit ird, rqv, input logic [31:0] rqa,
                       input bit iv, input logic [31:0] ipc, ic, input bit br, xv,
                       input logic [31:0] xc);
        vec_t v;
        v.rst = rst_v; v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.rdr = rdr;
        v.rpc = rpc; v.ird = ird; v.rqv = rqv; v.rqa = rqa; v.iv = iv; v.ipc = ipc;
        v.ic = ic; v.br = br; v.xv = xv; v.xc = xc;
        vecs.push_back(v);
    endtask

    function automatic obs_t observe();
        obs_t o;
        o = '{rqv: req_valid, rqa: req_addr, iv: instr_valid, ipc: instr_pc,
              ic: instr_content, br: bp_is_branch, bd: bp_decision, pred: bp_pred_addr,
              xv: xcpt_valid, xo: xcpt_origin, xc: xcpt_cause};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got rqv=%b rqa=%h iv=%b ipc=%h ic=%h br=%b bd=%b pred=%h xv=%b xo=%h xc=%h | want rqv=%b rqa=%h iv=%b ipc=%h ic=%h br=%b bd=%b pred=%h xv=%b xo=%h xc=%h",
                     name, act.rqv, act.rqa, act.iv, act.ipc, act.ic, act.br, act.bd, act.pred,
                     act.xv, act.xo, act.xc, exp.rqv, exp.rqa, exp.iv, exp.ipc, exp.ic, exp.br,
                     exp.bd, exp.pred, exp.xv, exp.xo, exp.xc);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst_v, rdy, rv, input logic [31:0] rd, input bit re, rdr,
                         input logic [31:0] rpc, input bit ird);
        rst = rst_v; req_ready = rdy; rsp_valid = rv; rsp_data = rd; rsp_error = re;
        redirect_valid = rdr; redirect_pc = rpc; instr_ready = ird;
    endtask

    localparam logic [31:0] D0 = 32'h0000_0013;  // addi
    localparam logic [31:0] D1 = 32'h0020_8463;  // beq
    localparam logic [31:0] D2 = 32'h0080_006F;  // jal
    localparam logic [31:0] D3 = 32'h0000_8067;  // jalr
    localparam logic [31:0] D4 = 32'h0010_0093;  // addi
    localparam logic [31:0] D5 = 32'h0020_8133;  // add
    localparam logic [31:0] D6 = 32'h0000_1017;  // auipc
    localparam logic [31:0] D7 = 32'h0000_0013;
    localparam logic [31:0] D8 = 32'h00C0_006F;  // jal
    localparam logic [31:0] D9 = 32'h0050_0113;
    localparam logic [31:0] XX = 32'hDEAD_BEEF;  // payload of responses that must be dropped

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        //   rst rdy rv data    re rdr rpc          ird | rqv rqa          iv ipc          ic  br xv xc
        row(1, 0, 0, '0, 0, 0, '0, 0,            0, 32'h1000, 0, '0, '0, 0, 0, 0);
        // streaming start, request hold while not ready
        row(0, 1, 0, '0, 0, 0, '0, 1,            1, 32'h1000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 1, D0, 0, 0, '0, 1,            1, 32'h1004, 0, '0, '0, 0, 0, 0);
        row(0, 1, 1, D1, 0, 0, '0, 1,            1, 32'h1008, 1, 32'h1000, D0, 0, 0, 0);
        row(0, 0, 1, D2, 0, 0, '0, 1,            1, 32'h100C, 1, 32'h1004, D1, 1, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 0,            1, 32'h100C, 1, 32'h1008, D2, 1, 0, 0);
        // fill the queue with decode stalled
        row(0, 1, 0, '0, 0, 0, '0, 0,            1, 32'h100C, 1, 32'h1008, D2, 1, 0, 0);
        row(0, 1, 1, D3, 0, 0, '0, 0,            1, 32'h1010, 1, 32'h1008, D2, 1, 0, 0);
        row(0, 1, 1, D4, 0, 0, '0, 0,            1, 32'h1014, 1, 32'h1008, D2, 1, 0, 0);
        row(0, 1, 1, D5, 0, 0, '0, 0,            0, 32'h1018, 1, 32'h1008, D2, 1, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 0,            0, 32'h1018, 1, 32'h1008, D2, 1, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            0, 32'h1018, 1, 32'h1008, D2, 1, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 0,            1, 32'h1018, 1, 32'h100C, D3, 1, 0, 0);
        // drain, then three outstanding and a redirect
        row(0, 0, 0, '0, 0, 0, '0, 1,            1, 32'h1018, 1, 32'h100C, D3, 1, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 1,            1, 32'h1018, 1, 32'h1010, D4, 0, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 1,            1, 32'h1018, 1, 32'h1014, D5, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            1, 32'h1018, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            1, 32'h101C, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            1, 32'h1020, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 1, 32'h2000, 1,      0, 32'h1024, 0, '0, '0, 0, 0, 0);
        row(0, 1, 1, XX, 0, 0, '0, 1,            1, 32'h2000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 1, XX, 0, 0, '0, 1,            1, 32'h2004, 0, '0, '0, 0, 0, 0);
        row(0, 0, 1, XX, 0, 0, '0, 1,            1, 32'h2008, 0, '0, '0, 0, 0, 0);
        row(0, 0, 1, D6, 0, 0, '0, 0,            1, 32'h2008, 0, '0, '0, 0, 0, 0);
        row(0, 0, 1, D7, 0, 0, '0, 0,            1, 32'h2008, 1, 32'h2000, D6, 0, 0, 0);
        // redirect and response together while decode has a pending head
        row(0, 1, 0, '0, 0, 0, '0, 0,            1, 32'h2008, 1, 32'h2000, D6, 0, 0, 0);
        row(0, 0, 1, XX, 0, 1, 32'h3000, 1,      0, 32'h200C, 0, 32'h2000, D6, 0, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 1,            1, 32'h3000, 0, '0, '0, 0, 0, 0);
        // misaligned redirect halts, aligned redirect resumes
        row(0, 1, 0, '0, 0, 1, 32'h3002, 0,      0, 32'h3000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 0,            0, 32'h3000, 1, 32'h3002, '0, 0, 1, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            0, 32'h3000, 1, 32'h3002, '0, 0, 1, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            0, 32'h3000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 1, 32'h3000, 1,      0, 32'h3000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            1, 32'h3000, 0, '0, '0, 0, 0, 0);
        row(0, 0, 1, D8, 0, 0, '0, 1,            1, 32'h3004, 0, '0, '0, 0, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 1,            1, 32'h3004, 1, 32'h3000, D8, 1, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            1, 32'h3004, 0, '0, '0, 0, 0, 0);
        // reset with a request in flight, then an access fault at 0x1004
        row(1, 1, 1, XX, 0, 0, '0, 1,            0, 32'h1000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 0,            1, 32'h1000, 0, '0, '0, 0, 0, 0);
        row(0, 1, 1, D9, 0, 0, '0, 0,            1, 32'h1004, 0, '0, '0, 0, 0, 0);
        row(0, 0, 1, 32'h1234_5678, 1, 0, '0, 0, 1, 32'h1008, 1, 32'h1000, D9, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 1,            0, 32'h1008, 1, 32'h1000, D9, 0, 0, 0);
        row(0, 1, 0, '0, 0, 0, '0, 0,            0, 32'h1008, 1, 32'h1004, '0, 0, 1, 1);
        row(0, 1, 0, '0, 0, 0, '0, 1,            0, 32'h1008, 1, 32'h1004, '0, 0, 1, 1);
        row(0, 1, 0, '0, 0, 0, '0, 1,            0, 32'h1008, 0, '0, '0, 0, 0, 0);
        row(0, 1, 0, '0, 0, 1, 32'h1004, 1,      0, 32'h1008, 0, '0, '0, 0, 0, 0);
        row(0, 0, 0, '0, 0, 0, '0, 1,            1, 32'h1004, 0, '0, '0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            obs_t exp;
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].re,
                  vecs[i].rdr, vecs[i].rpc, vecs[i].ird);
            #1;
            exp = '{rqv: vecs[i].rqv, rqa: vecs[i].rqa, iv: vecs[i].iv, ipc: vecs[i].ipc,
                    ic: vecs[i].ic, br: vecs[i].br, bd: 1'b0, pred: vecs[i].ipc + 32'd4,
                    xv: vecs[i].xv, xo: vecs[i].ipc, xc: vecs[i].xc};
            check($sformatf("row%0d", i), observe(), exp);
        end

        // Streaming with a one-cycle memory: decode must see consecutive PCs from 0x1004.
        begin
            bit          fired_prev = 1'b0;
            bit          fired;
            logic [31:0] exp_pc = 32'h1004;
            int          decoded = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                drive(1'b0, 1'b1, fired_prev, 32'h0000_0013, 1'b0, 1'b0, '0, 1'b1);
                #1;
                fired = req_valid & req_ready;
                if (instr_valid) begin
                    check_word($sformatf("stream_pc%0d", decoded), instr_pc, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    decoded++;
                end
                fired_prev = fired;
            end
            check_word("stream_count", 32'(decoded), 32'd10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/simple_instr_fetch.md
SIMPLE_INSTR_FETCH -- requirements
Module: simple_instr_fetch

Interface
REQ-001 The block SHALL have parameter VADDR_WIDTH, default 32, virtual address width.
REQ-002 The block SHALL have parameter MAX_ILEN, default 32, instruction width.
REQ-003 The block SHALL have parameter XCPT_CAUSE_WIDTH, default 32, exception cause width.
REQ-004 The block SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries (power of two, >=2).
REQ-005 The block SHALL have parameter BOOT_ADDR, default 32'h0000_1000, PC after reset.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset: clk_i input 1, the single clock, all state on rising edge.
REQ-007 rst_i input 1: asynchronous active-high reset.
REQ-008 imem_req_valid_o output 1; imem_req_ready_i input 1; imem_req_addr_o output VADDR_WIDTH: fetch request.
REQ-009 imem_rsp_valid_i input 1; imem_rsp_data_i input MAX_ILEN; imem_rsp_error_i input 1: in-order response, always accepted.
REQ-010 redirect_valid_i input 1; redirect_pc_i input VADDR_WIDTH: PC redirect from backend.
REQ-011 instr_valid_o output 1; instr_ready_i input 1: decode handshake.
REQ-012 instr_pc_o output VADDR_WIDTH; instr_content_o output MAX_ILEN: instruction to decode.
REQ-013 bp_is_branch_o output 1; bp_decision_o output 1; bp_pred_addr_o output VADDR_WIDTH: prediction info.
REQ-014 xcpt_valid_o output 1; xcpt_origin_o output VADDR_WIDTH; xcpt_cause_o output XCPT_CAUSE_WIDTH: fetch exception.

Function
REQ-015 States SHALL be RUN and HALT; reset -> RUN; RUN -> HALT when an exception entry is enqueued; HALT -> RUN only on redirect_valid_i with word-aligned redirect_pc_i.
REQ-016 fetch PC register SHALL reset to BOOT_ADDR and advance by 4 on each request handshake (valid & ready); wrap modulo 2^VADDR_WIDTH.
REQ-017 imem_req_valid_o SHALL be 1 iff state RUN, no redirect this cycle, and (queue count + outstanding) < FQ_DEPTH; imem_req_addr_o = fetch PC.
REQ-018 Once asserted, imem_req_valid_o and imem_req_addr_o SHALL hold until handshake, except they drop in a redirect cycle.
REQ-019 outstanding counter SHALL increment on request handshake, decrement on imem_rsp_valid_i, both in one cycle -> unchanged.
REQ-020 Each accepted response SHALL enqueue {pc, data, error}, pc = address of its request, unless discarded (REQ-024).
REQ-021 A response with imem_rsp_error_i=1 SHALL enqueue an exception entry with cause 1 (access fault), origin = its pc, and move to HALT.
REQ-022 Decode output SHALL present the queue head: instr_valid_o = queue non-empty and no redirect this cycle; head pops on instr_valid_o & instr_ready_i; enqueue and pop in one cycle at full or empty SHALL both succeed.
REQ-023 xcpt_valid_o SHALL equal instr_valid_o & head.error; xcpt_origin_o = head.pc; xcpt_cause_o = head cause; instr_content_o = 0 for exception entries.
REQ-024 On redirect_valid_i: queue flushed, discard counter loaded with outstanding (minus 1 if a response arrives that cycle), that response dropped; later responses dropped while discard counter > 0, decrementing it.
REQ-025 Redirect with redirect_pc_i[1:0] == 0 SHALL set fetch PC to redirect_pc_i and state RUN; with non-zero low bits SHALL enqueue an exception entry, cause 0 (misaligned), origin redirect_pc_i, no memory request, state HALT.
REQ-026 Static not-taken prediction: bp_is_branch_o = 1 iff head opcode[6:0] is 7'b1100011, 7'b1101111 or 7'b1100111; bp_decision_o = 0; bp_pred_addr_o = instr_pc_o + 4.
REQ-027 Redirect SHALL take priority over response, request and pop in the same cycle.

Reset
REQ-028 On rst_i: fetch PC = BOOT_ADDR, state RUN, queue empty, outstanding = 0, discard = 0.
REQ-029 During and right after reset, all valid outputs SHALL be 0; imem_req_addr_o = BOOT_ADDR; other outputs 0 except bp_pred_addr_o = 4.
REQ-030 Reset asserted mid-operation SHALL drop all in-flight state immediately without waiting for outstanding responses.

Verification
REQ-031 Reset release, imem_req_ready_i=1, 1-cycle response latency, instr_ready_i=1 -> requests at 0x1000, 0x1004, 0x1008...; decode sees same PCs in order.
REQ-032 instr_ready_i=0, memory always ready -> exactly 4 requests issued, queue full, imem_req_valid_o=0 until one pop.
REQ-033 3 requests outstanding, redirect to 0x2000 -> those 3 responses dropped, next decoded PC 0x2000.
REQ-034 Response with error for PC 0x1004 -> xcpt_valid_o=1, origin 0x1004, cause 1; no further requests until redirect.
REQ-035 Redirect to 0x3002 -> exception entry origin 0x3002, cause 0, no request; later redirect 0x3000 resumes fetch.
REQ-036 Redirect and response in same cycle with instr_valid_o pending -> response dropped, instr_valid_o=0 that cycle, queue empty next cycle.
